// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave register bank with read-back, frame-length checking and write strobe.
module spi_reg_bank #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic SCLK,
  input  logic nCS,
  input  logic MOSI,
  output logic MISO,
  output logic miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic frame_err
);
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, mosi_sync;
  logic sclk_d, ncs_d;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ncs_sync <= '1;
      sclk_d <= 1'b0;
      ncs_d <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ncs_sync <= {ncs_sync[SYNC_STAGES-2:0], nCS};
      sclk_d <= sclk_sync[SYNC_STAGES-1];
      ncs_d <= ncs_sync[SYNC_STAGES-1];
    end
  logic sclk_s, ncs_s, mosi_s, sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ncs_s = ncs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ncs_rise = ncs_s & ~ncs_d;
  assign ncs_fall = ~ncs_s & ncs_d;
  assign miso_oe = ~ncs_s;
  logic [FRAME_LEN-1:0] shift;
  logic [CNT_W-1:0] cnt;
  logic ovf, cur_bit, full, frame_rw, in_range;
  logic [DATA_W-1:0] miso_sr, frame_data, rd_word;
  logic [ADDR_W-1:0] frame_addr, rd_addr;
  assign full = cnt == CNT_W'(FRAME_LEN);
  assign frame_rw = shift[FRAME_LEN-1];
  assign frame_addr = shift[DATA_W +: ADDR_W];
  assign frame_data = shift[DATA_W-1:0];
  assign in_range = {1'b0, frame_addr} < (ADDR_W+1)'(NUM_REGS);
  // address as it will stand once the bit now on MOSI is shifted in
  assign rd_addr = {shift[ADDR_W-2:0], mosi_s};
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == ADDR_W'(i)) rd_word = regs_out[i*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      regs_out <= '0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      frame_err <= 1'b0;
      MISO <= 1'b0;
      cur_bit <= 1'b0;
      miso_sr <= '0;
      shift <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      MISO <= ~ncs_s & cur_bit;
      if (ncs_fall) begin
        cnt <= '0;
        shift <= '0;
        ovf <= 1'b0;
        miso_sr <= '0;
        cur_bit <= 1'b0;
      end else if (ncs_rise) begin
        cnt <= '0;
        miso_sr <= '0;
        cur_bit <= 1'b0;
        if (full && !ovf && frame_rw && in_range) begin
          for (int i = 0; i < NUM_REGS; i++)
            if (frame_addr == ADDR_W'(i)) regs_out[i*DATA_W +: DATA_W] <= frame_data;
          wr_strobe <= 1'b1;
          wr_addr <= frame_addr;
        end else if (cnt != '0 && !(full && !ovf && !frame_rw)) frame_err <= 1'b1;
      end else if (!ncs_s) begin
        if (sclk_rise) begin
          if (full) ovf <= 1'b1;
          else begin
            shift <= {shift[FRAME_LEN-2:0], mosi_s};
            cnt <= cnt + 1'b1;
          end
          if (cnt == CNT_W'(ADDR_W)) miso_sr <= shift[ADDR_W-1] ? '0 : rd_word;
        end else if (sclk_fall) begin
          cur_bit <= miso_sr[DATA_W-1];
          miso_sr <= miso_sr << 1;
        end
      end
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: random and directed SPI frames on two parameterisations against a register-array model.
module tb_spi_reg_bank;
  logic clk = 1'b0, nrst = 1'b0;
  logic [1:0] sclk = '0, ncs = '1, mosi = '0, miso, oe, ws, fe;
  logic [39:0] r0;
  logic [255:0] r1;
  logic [6:0] wa0;
  logic [3:0] wa1;
  always #5 clk = ~clk;
  spi_reg_bank u0 (
    .clk(clk), .nrst(nrst), .SCLK(sclk[0]), .nCS(ncs[0]), .MOSI(mosi[0]), .MISO(miso[0]),
    .miso_oe(oe[0]), .regs_out(r0), .wr_strobe(ws[0]), .wr_addr(wa0), .frame_err(fe[0])
  );
  spi_reg_bank #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4)) u1 (
    .clk(clk), .nrst(nrst), .SCLK(sclk[1]), .nCS(ncs[1]), .MOSI(mosi[1]), .MISO(miso[1]),
    .miso_oe(oe[1]), .regs_out(r1), .wr_strobe(ws[1]), .wr_addr(wa1), .frame_err(fe[1])
  );
  localparam int NR [2] = '{5, 16};
  localparam int DW [2] = '{8, 16};
  localparam int AW [2] = '{7, 4};
  int n_chk = 0, n_fail = 0;
  int n_ws [2] = '{0, 0};
  int n_fe [2] = '{0, 0};
  int e_ws [2] = '{0, 0};
  int e_fe [2] = '{0, 0};
  logic [31:0] e_wa [2];
  logic [31:0] m [2][16];
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      if (ws[k]) n_ws[k]++;
      if (fe[k]) n_fe[k]++;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] msk(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
  function automatic logic [31:0] dreg(input int s, input int i);
    return s ? 32'(r1[i*16 +: 16]) : 32'(r0[i*8 +: 8]);
  endfunction
  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      e_wa[s] = '0;
      for (int i = 0; i < 16; i++) m[s][i] = '0;
    end
  endtask
  task automatic check_state(input int s);
    for (int i = 0; i < NR[s]; i++) chk($sformatf("reg%0d_%0d", s, i), dreg(s, i), m[s][i]);
    chk($sformatf("wr_strobes%0d", s), n_ws[s], e_ws[s]);
    chk($sformatf("frame_errs%0d", s), n_fe[s], e_fe[s]);
    chk($sformatf("wr_addr%0d", s), s ? 32'(wa1) : 32'(wa0), e_wa[s]);
    chk($sformatf("miso_idle%0d", s), 32'(miso[s]), 0);
    chk($sformatf("oe_idle%0d", s), 32'(oe[s]), 0);
  endtask
  task automatic sbit(input int s, input logic b);
    mosi[s] = b;
    sclk[s] = 1'b1;
    cyc(6);
    sclk[s] = 1'b0;
    cyc(6);
  endtask
  task automatic frame(input int s, input logic [63:0] bits, input int nb);
    int al, dl, fl;
    logic [31:0] cap, addr, data;
    al = AW[s];
    dl = DW[s];
    fl = 1 + al + dl;
    cap = '0;
    ncs[s] = 1'b0;
    cyc(6);
    chk($sformatf("oe_active%0d", s), 32'(oe[s]), 1);
    for (int i = 0; i < nb; i++) begin
      if (i >= al + 1) cap = {cap[30:0], miso[s]};
      sbit(s, bits[nb-1-i]);
    end
    ncs[s] = 1'b1;
    cyc(8);
    addr = 32'((bits >> dl) & msk(al));
    data = 32'(bits & msk(dl));
    if (nb == fl) begin
      if (bits[nb-1]) begin
        if (int'(addr) < NR[s]) begin
          m[s][addr] = data;
          e_ws[s]++;
          e_wa[s] = addr;
        end else e_fe[s]++;
      end else chk($sformatf("rd%0d_a%0d", s, addr), cap & 32'(msk(dl)), int'(addr) < NR[s] ? m[s][addr] : 0);
    end else if (nb != 0) e_fe[s]++;
    check_state(s);
  endtask
  function automatic logic [63:0] mk(input int s, input logic rw, input logic [31:0] a, input logic [31:0] d);
    return (64'(rw) << (AW[s] + DW[s])) | ((64'(a) & msk(AW[s])) << DW[s]) | (64'(d) & msk(DW[s]));
  endfunction
  initial begin
    int s, fl, nb;
    clear_model();
    cyc(3);
    check_state(0);
    check_state(1);
    nrst = 1'b1;
    cyc(4);
    frame(0, mk(0, 1, 2, 'hA5), 16);
    frame(0, mk(0, 0, 2, 0), 16);
    frame(0, mk(0, 1, 9, 'hFF), 16);
    frame(0, mk(0, 0, 9, 0), 16);
    frame(0, 64'h2AB, 10);
    frame(0, 64'h1_82A5, 17);
    frame(0, 64'h0, 0);
    ncs[0] = 1'b0;
    cyc(6);
    for (int i = 0; i < 12; i++) sbit(0, i[0]);
    nrst = 1'b0;
    cyc(2);
    clear_model();
    check_state(1);
    for (int i = 0; i < NR[0]; i++) chk($sformatf("rst_reg%0d", i), dreg(0, i), 0);
    chk("rst_miso", 32'(miso[0]), 0);
    chk("rst_wr_addr", 32'(wa0), 0);
    nrst = 1'b1;
    cyc(2);
    ncs[0] = 1'b1;
    cyc(8);
    check_state(0);
    frame(0, mk(0, 1, 0, 'h3C), 16);
    frame(1, mk(1, 1, 15, 'hBEEF), 21);
    frame(1, mk(1, 0, 15, 0), 21);
    repeat (40) begin
      s = int'($urandom_range(0, 1));
      fl = 1 + AW[s] + DW[s];
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, fl + 3)) : fl;
      frame(s, mk(s, 1'($urandom_range(0, 1)), $urandom_range(0, NR[s] + 2), $urandom), nb);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI-slave register bank, successor to the single-purpose SPI peripheral that drives the PWM enable and duty-cycle registers. Receives SPI mode-0 frames from an off-chip master, writes a configurable array of NUM_REGS registers of DATA_W bits, and adds read-back over MISO, frame-length checking and a write strobe. SCLK, nCS and MOSI are oversampled in the `clk` domain; SCLK is never used as a clock. The block sits between the chip pins and the PWM/output-enable logic, which consumes the flattened `regs_out` bus.

## Interface
Parameters:
- NUM_REGS, 5: number of registers; valid addresses 0..NUM_REGS-1 (1..2**ADDR_W).
- DATA_W, 8: register and data-phase width in bits (1..32).
- ADDR_W, 7: address-phase width in bits.
- SYNC_STAGES, 2: synchroniser flops per input (≥2).

Ports:
- clk  in  1  system clock; all logic in this domain.
- nrst  in  1  reset, asynchronous assert, active-low; one clock, reset asynchronous and active-low.
- SCLK  in  1  SPI clock, asynchronous to clk.
- nCS  in  1  SPI chip select, active-low, asynchronous.
- MOSI  in  1  SPI data in, asynchronous.
- MISO  out  1  SPI data out.
- miso_oe  out  1  1 while synchronised nCS is low (pad tristate enable).
- regs_out  out  NUM_REGS*DATA_W  register array; register i at bits [i*DATA_W +: DATA_W].
- wr_strobe  out  1  one-cycle pulse when a write commits.
- wr_addr  out  ADDR_W  address of last committed write; valid with and after wr_strobe.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Frame, MSB first: 1 R/W bit (1 = write, 0 = read), ADDR_W address bits, DATA_W data bits; FRAME_LEN = 1+ADDR_W+DATA_W.
- Each input passes a SYNC_STAGES chain; nCS chain resets to 1, SCLK/MOSI chains to 0. Edges detected by comparing last sync stage with one extra registered copy.
- Synchronised nCS falling edge: bit counter, shift register and overflow flag cleared.
- Synchronised SCLK rising edge with nCS low: MOSI shifted in, counter increments, saturating at FRAME_LEN; a rising edge when counter == FRAME_LEN sets overflow.
- Read: on the rising edge that captures the last address bit, the MISO shift register loads the addressed register (0 if address ≥ NUM_REGS). On each subsequent SCLK falling edge MISO presents the next bit, MSB first; after DATA_W bits MISO holds 0. MISO is 0 outside the data phase of a read and whenever nCS is high.
- Synchronised nCS rising edge, commit decision:
  - counter == FRAME_LEN, no overflow, R/W = 1, address < NUM_REGS: write data into that register, pulse wr_strobe, update wr_addr.
  - counter == FRAME_LEN, no overflow, R/W = 0: no write, no error.
  - otherwise (short, long, write to out-of-range address): discard, pulse frame_err.
  - nCS rising edge with counter == 0: no action, no error.
- Simultaneous synchronised nCS rise and SCLK edge in the same clk cycle: nCS rise takes precedence, SCLK edge ignored.
- Reset (any time, including mid-frame): regs_out = 0, MISO = 0, miso_oe = 0, wr_strobe = 0, wr_addr = 0, frame_err = 0, counter/shift/overflow = 0; the partial frame is lost.

## Timing
- Input latency: SYNC_STAGES+1 clk cycles from pin to detected edge.
- Commit: regs_out, wr_strobe and wr_addr update on the clk edge that detects the nCS rise, i.e. SYNC_STAGES+1 cycles after the pin rises; frame_err has the same timing.
- MISO changes SYNC_STAGES+2 cycles after the SCLK pin falling edge.
- Supported SCLK: high and low phases each ≥ SYNC_STAGES+3 clk cycles. nCS setup to first SCLK rise and hold after last SCLK fall ≥ SYNC_STAGES+2 cycles.
- Back-to-back frames: nCS high ≥ 2 clk cycles after synchronisation.

## Test plan
- Write reg 2 with 0xA5 (frame 1,0000010,10100101) -> regs_out[23:16] = 0xA5, all other regs 0, one wr_strobe pulse, wr_addr = 2.
- Read reg 2 after the previous write -> MISO shifts 1,0,1,0,0,1,0,1 on data-phase falling edges; regs unchanged; no wr_strobe or frame_err.
- Write to address 9 (≥ NUM_REGS) with 0xFF -> no register changes, one frame_err pulse; a read of address 9 returns 0x00 with no frame_err.
- Frame aborted after 10 bits, then a frame of 17 bits -> both discarded, frame_err pulses twice, regs unchanged.
- Assert nrst mid-write after 12 bits, release, send full write reg 0 = 0x3C -> all regs 0 after reset, then regs_out[7:0] = 0x3C.
- Parameter variant NUM_REGS = 16, DATA_W = 16, ADDR_W = 4: write reg 15 = 0xBEEF, read it back -> regs_out[255:240] = 0xBEEF, MISO returns 0xBEEF.
